// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the two-master SDRAM arbiter
package sdram_arb_pkg;
   localparam int PEND_BC_W = 8;
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   typedef logic owner_t;
   localparam owner_t OWNER_VGA = 1'b0;
   localparam owner_t OWNER_CPU = 1'b1;
   typedef struct packed {
      owner_t                 owner;
      logic [PEND_BC_W-1:0]   burstcount;
   } pend_entry_t;
   function automatic logic [PEND_BC_W-1:0] norm_bc(input logic [PEND_BC_W-1:0] bc);
      return (bc == '0) ? PEND_BC_W'(1) : bc;
   endfunction
endpackage

// File: rtl/sdram_arb_pend_fifo.sv
// sdram_arb_pend_fifo: outstanding read-burst FIFO, push on full is legal when popping
module sdram_arb_pend_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  pend_entry_t din,
   output pend_entry_t head,
   output logic        full,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);
   pend_entry_t mem [DEPTH];
   logic [AW:0] wp, rp;
   logic wr, rd;
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign head  = mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (wr) mem[wp[AW-1:0]] <= din;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority two-master Avalon-MM arbiter with starvation guard and read routing
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int BURST_W    = 8,
   parameter int STARVE_MAX = 64,
   parameter int MAX_PEND   = 8
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic [BURST_W-1:0]  m0_burstcount,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [BURST_W-1:0]  m1_burstcount,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic [BURST_W-1:0]  s_burstcount,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic [1:0]          grant,
   output logic                rd_orphan
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   state_t               state;
   logic [PEND_BC_W-1:0] wr_cnt, ret_cnt, bc_n;
   logic [SW-1:0]        starve_cnt;
   logic                 g0, g1, wr_busy, m1_req, m0_elig, m1_elig;
   logic                 rd_acc, wr_acc, rdv, hit, last, full, empty;
   pend_entry_t          push_entry, head;
   assign g0      = reset_reset_n && state == GNT0;
   assign g1      = reset_reset_n && state == GNT1;
   assign grant   = {g1, g0};
   assign wr_busy = wr_cnt != '0;
   assign m1_req  = m1_read || m1_write;
   assign m0_elig = m0_read && !full;
   assign m1_elig = m1_write || (m1_read && !full);
   assign bc_n    = norm_bc(PEND_BC_W'(m1_burstcount));
   assign s_address    = g1 ? m1_address : m0_address;
   assign s_read       = (g0 && m0_read) || (g1 && m1_read && !m1_write && !wr_busy);
   assign s_write      = g1 && m1_write;
   assign s_writedata  = m1_writedata;
   assign s_byteenable = g1 ? m1_byteenable : '1;
   assign s_burstcount = g1 ? m1_burstcount : m0_burstcount;
   assign m0_waitrequest = !g0 || s_waitrequest;
   assign m1_waitrequest = !g1 || s_waitrequest;
   assign rd_acc = s_read && !s_waitrequest;
   assign wr_acc = s_write && !s_waitrequest;
   assign push_entry = '{owner: g1 ? OWNER_CPU : OWNER_VGA,
                         burstcount: norm_bc(PEND_BC_W'(s_burstcount))};
   // Return path: the FIFO head owns every beat until its burst is complete
   assign rdv  = reset_reset_n && s_readdatavalid;
   assign hit  = rdv && !empty;
   assign last = hit && ret_cnt == head.burstcount - 1'b1;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = hit && head.owner == OWNER_VGA;
   assign m1_readdatavalid = hit && head.owner == OWNER_CPU;
   sdram_arb_pend_fifo #(.DEPTH(MAX_PEND)) u_pend (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .push  (rd_acc),
      .pop   (last),
      .din   (push_entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state      <= IDLE;
         wr_cnt     <= '0;
         ret_cnt    <= '0;
         starve_cnt <= '0;
         rd_orphan  <= 1'b0;
      end else begin
         if (state != GNT1 && m1_req && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
         if (rdv && empty) rd_orphan <= 1'b1;
         if (hit) ret_cnt <= last ? '0 : ret_cnt + 1'b1;
         case (state)
            IDLE:
               if (m1_elig && starve_cnt == STARVE_TOP) begin
                  state      <= GNT1;
                  starve_cnt <= '0;
               end else if (m0_elig) begin
                  state <= GNT0;
               end else if (m1_elig) begin
                  state      <= GNT1;
                  starve_cnt <= '0;
               end
            GNT0:
               if (rd_acc || !m0_read) state <= IDLE;
            GNT1:
               if (wr_acc) begin
                  wr_cnt <= wr_busy ? wr_cnt - 1'b1 : bc_n - 1'b1;
                  if (wr_busy ? wr_cnt == 1 : bc_n == 1) state <= IDLE;
               end else if (!wr_busy && (rd_acc || !m1_req)) begin
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scenario tasks with a read-return scoreboard for sdram_arbiter
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;
   typedef struct packed {
      logic        owner;
      logic [15:0] data;
   } beat_t;
   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic [24:0] m0_address, m1_address, s_address;
   logic        m0_read, m1_read, m1_write, s_read, s_write;
   logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
   logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
   logic [15:0] m0_readdata, m1_readdata, m1_writedata, s_writedata, s_readdata;
   logic        m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
   logic [1:0]  m1_byteenable, s_byteenable, grant;
   logic        rd_orphan;
   int          errs = 0;
   int          checks = 0;
   beat_t       rq[$];
   logic [15:0] wq[$];
   always #5 clk_clk = ~clk_clk;
   sdram_arbiter dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_burstcount(m0_burstcount),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .grant(grant), .rd_orphan(rd_orphan)
   );
   task automatic drive_idle();
      m0_address = '0; m0_read = 0; m0_burstcount = 8'd1;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
      m1_byteenable = 2'b11; m1_burstcount = 8'd1;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
   endtask
   task automatic test_reset();
      drive_idle();
      reset_reset_n = 0; m0_read = 1; m0_burstcount = 8'd4; s_readdatavalid = 1;
      @(posedge clk_clk); @(negedge clk_clk); #1;
      checks++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if ({s_read, s_write} !== 2'b00) begin errs++; $display("FAIL reset_cmd got=%b exp=00", {s_read, s_write}); end
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errs++; $display("FAIL reset_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest}); end
      checks++; if ({m0_readdatavalid, m1_readdatavalid, rd_orphan} !== 3'b000) begin errs++; $display("FAIL reset_rdv got=%b exp=000", {m0_readdatavalid, m1_readdatavalid, rd_orphan}); end
      @(negedge clk_clk); drive_idle(); reset_reset_n = 1;
      repeat (3) begin
         @(negedge clk_clk); #1;
         checks++; if (grant !== 2'b00) begin errs++; $display("FAIL idle_grant got=%b exp=00", grant); end
      end
   endtask
   task automatic test_both_read();
      beat_t b;
      for (int i = 0; i < 8; i++) begin b.owner = (i >= 4); b.data = 16'hA000 + 16'(i); rq.push_back(b); end
      @(negedge clk_clk);
      m0_address = 25'h100; m0_read = 1; m0_burstcount = 8'd4;
      m1_address = 25'h200; m1_read = 1; m1_burstcount = 8'd4;
      @(negedge clk_clk); #1;
      checks++; if (grant !== 2'b01 || s_read !== 1 || s_address !== 25'h100 || m0_waitrequest !== 0 || m1_waitrequest !== 1)
         begin errs++; $display("FAIL both_m0_first grant=%b rd=%b addr=%h w0=%b w1=%b exp 01/1/100/0/1", grant, s_read, s_address, m0_waitrequest, m1_waitrequest); end
      @(negedge clk_clk); m0_read = 0; #1;
      checks++; if (grant !== 2'b00) begin errs++; $display("FAIL both_gap grant=%b exp=00", grant); end
      @(negedge clk_clk); #1;
      checks++; if (grant !== 2'b10 || s_read !== 1 || s_address !== 25'h200 || s_burstcount !== 8'd4)
         begin errs++; $display("FAIL both_m1_second grant=%b rd=%b addr=%h bc=%0d exp 10/1/200/4", grant, s_read, s_address, s_burstcount); end
      @(negedge clk_clk); m1_read = 0;
      while (rq.size() > 0) begin
         b = rq.pop_front();
         s_readdatavalid = 1; s_readdata = b.data; #1;
         checks++;
         if ({m1_readdatavalid, m0_readdatavalid} !== {b.owner, !b.owner} || (b.owner ? m1_readdata : m0_readdata) !== b.data)
            begin errs++; $display("FAIL both_return rdv=%b%b data=%h exp_owner=%0d exp_data=%h", m1_readdatavalid, m0_readdatavalid, b.owner ? m1_readdata : m0_readdata, b.owner, b.data); end
         @(negedge clk_clk);
      end
      s_readdatavalid = 0;
   endtask
   task automatic test_write_burst();
      logic [15:0] exp;
      for (int k = 0; k < 8; k++) wq.push_back(16'hC000 + 16'(k * 17));
      @(negedge clk_clk);
      m1_address = 25'h300; m1_write = 1; m1_burstcount = 8'd8; m1_writedata = wq[0]; #1;
      checks++; if (grant !== 2'b00) begin errs++; $display("FAIL wr_pre grant=%b exp=00", grant); end
      for (int k = 0; k < 8; k++) begin
         exp = wq.pop_front();
         for (int st = (k >= 2 && k <= 4) ? 1 : 0; st >= 0; st--) begin
            @(negedge clk_clk);
            m1_writedata = exp; s_waitrequest = (st == 1);
            if (k >= 2) begin m0_read = 1; m0_address = 25'h400; m0_burstcount = 8'd1; end
            #1;
            checks++;
            if (grant !== 2'b10 || s_write !== 1 || s_writedata !== exp || m1_waitrequest !== (st == 1) || m0_waitrequest !== 1)
               begin errs++; $display("FAIL wr_beat%0d grant=%b wr=%b data=%h w1=%b w0=%b exp 10/1/%h/%0d/1", k, grant, s_write, s_writedata, m1_waitrequest, m0_waitrequest, exp, st); end
         end
      end
      @(negedge clk_clk); m1_write = 0; s_waitrequest = 0; #1;
      checks++; if (grant !== 2'b00) begin errs++; $display("FAIL wr_gap grant=%b exp=00", grant); end
      @(negedge clk_clk); #1;
      checks++; if (grant !== 2'b01 || s_address !== 25'h400) begin errs++; $display("FAIL wr_then_m0 grant=%b addr=%h exp 01/400", grant, s_address); end
      @(negedge clk_clk); m0_read = 0; s_readdatavalid = 1; s_readdata = 16'h1234; #1;
      checks++; if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0 || m0_readdata !== 16'h1234)
         begin errs++; $display("FAIL wr_m0_return rdv=%b%b data=%h exp 01/1234", m1_readdatavalid, m0_readdatavalid, m0_readdata); end
      @(negedge clk_clk); s_readdatavalid = 0;
   endtask
   task automatic test_starve();
      int pend = 0;
      int c = 0;
      bit got = 0;
      @(negedge clk_clk);
      m0_read = 1; m0_address = 25'h500; m0_burstcount = 8'd1;
      m1_write = 1; m1_address = 25'h600; m1_burstcount = 8'd1; m1_writedata = 16'hBEEF;
      while (!got && c < 80) begin
         @(negedge clk_clk); c++;
         s_readdatavalid = pend > 0; s_readdata = 16'(c);
         if (pend > 0) pend--;
         #1;
         if (s_readdatavalid) begin
            checks++; if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0) begin errs++; $display("FAIL starve_return rdv=%b%b exp=01", m1_readdatavalid, m0_readdatavalid); end
         end
         if (s_read && !s_waitrequest) pend++;
         if (grant === 2'b10) got = 1;
      end
      checks++; if (!got || c < 64 || c > 67) begin errs++; $display("FAIL starve_latency got=%0d cycles granted=%0d exp 64..67", c, got); end
      checks++; if (dut.starve_cnt !== '0) begin errs++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt); end
      checks++; if (s_write !== 1 || s_writedata !== 16'hBEEF) begin errs++; $display("FAIL starve_write wr=%b data=%h exp 1/beef", s_write, s_writedata); end
      @(negedge clk_clk); m0_read = 0; m1_write = 0; s_readdatavalid = 0;
      while (pend > 0) begin
         s_readdatavalid = 1; pend--; #1;
         checks++; if (m0_readdatavalid !== 1) begin errs++; $display("FAIL starve_drain rdv0=%b exp=1", m0_readdatavalid); end
         @(negedge clk_clk);
      end
      s_readdatavalid = 0;
   endtask
   task automatic test_fifo_full();
      beat_t b;
      int acc = 0;
      int c = 0;
      int n = 0;
      @(negedge clk_clk); m0_read = 1; m0_address = 25'h700; m0_burstcount = 8'd2; #1;
      while (acc < 8 && c < 40) begin
         if (s_read && !s_waitrequest) begin
            acc++;
            repeat (2) begin b.owner = OWNER_VGA; b.data = 16'h7000 + 16'(n); n++; rq.push_back(b); end
         end
         if (acc < 8) begin @(negedge clk_clk); c++; #1; end
      end
      checks++; if (acc != 8) begin errs++; $display("FAIL full_issue accepted=%0d exp=8", acc); end
      repeat (4) begin
         @(negedge clk_clk); #1;
         checks++; if (grant !== 2'b00 || m0_waitrequest !== 1) begin errs++; $display("FAIL full_block grant=%b w0=%b exp 00/1", grant, m0_waitrequest); end
      end
      repeat (2) begin
         @(negedge clk_clk);
         b = rq.pop_front(); s_readdatavalid = 1; s_readdata = b.data; #1;
         checks++; if (m0_readdatavalid !== 1 || m0_readdata !== b.data || grant !== 2'b00)
            begin errs++; $display("FAIL full_first_ret rdv0=%b data=%h grant=%b exp 1/%h/00", m0_readdatavalid, m0_readdata, grant, b.data); end
      end
      @(negedge clk_clk); s_readdatavalid = 0; c = 0; #1;
      while (grant !== 2'b01 && c < 4) begin @(negedge clk_clk); c++; #1; end
      checks++; if (grant !== 2'b01 || c > 2) begin errs++; $display("FAIL full_release grant=%b after=%0d exp 01 within 2", grant, c); end
      repeat (2) begin b.owner = OWNER_VGA; b.data = 16'h7000 + 16'(n); n++; rq.push_back(b); end
      @(negedge clk_clk); m0_read = 0;
      while (rq.size() > 0) begin
         b = rq.pop_front(); s_readdatavalid = 1; s_readdata = b.data; #1;
         checks++; if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0 || m0_readdata !== b.data)
            begin errs++; $display("FAIL full_drain rdv=%b%b data=%h exp 01/%h", m1_readdatavalid, m0_readdatavalid, m0_readdata, b.data); end
         @(negedge clk_clk);
      end
      s_readdatavalid = 0;
   endtask
   task automatic test_orphan_reset();
      int c = 0;
      @(negedge clk_clk); s_readdatavalid = 1; s_readdata = 16'hDEAD; #1;
      checks++; if ({m1_readdatavalid, m0_readdatavalid, rd_orphan} !== 3'b000) begin errs++; $display("FAIL orphan_drop got=%b exp=000", {m1_readdatavalid, m0_readdatavalid, rd_orphan}); end
      @(negedge clk_clk); s_readdatavalid = 0; #1;
      checks++; if (rd_orphan !== 1) begin errs++; $display("FAIL orphan_set got=%b exp=1", rd_orphan); end
      m1_write = 1; m1_address = 25'h800; m1_burstcount = 8'd8; m1_writedata = 16'h5555;
      while (grant !== 2'b10 && c < 5) begin @(negedge clk_clk); c++; #1; end
      checks++; if (grant !== 2'b10) begin errs++; $display("FAIL orphan_wr_grant grant=%b exp=10", grant); end
      repeat (2) @(negedge clk_clk);
      #1;
      checks++; if (rd_orphan !== 1 || grant !== 2'b10) begin errs++; $display("FAIL orphan_sticky orphan=%b grant=%b exp 1/10", rd_orphan, grant); end
      @(negedge clk_clk); reset_reset_n = 0; #1;
      checks++; if (s_write !== 0 || grant !== 2'b00) begin errs++; $display("FAIL rst_mid_burst wr=%b grant=%b exp 0/00", s_write, grant); end
      @(negedge clk_clk); #1;
      checks++; if (dut.state !== IDLE || rd_orphan !== 0 || s_write !== 0)
         begin errs++; $display("FAIL rst_state state=%0d orphan=%b wr=%b exp IDLE/0/0", dut.state, rd_orphan, s_write); end
      @(negedge clk_clk); reset_reset_n = 1; m1_write = 0; #1;
      checks++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_release grant=%b exp=00", grant); end
   endtask
   initial begin
      #300000;
      $display("FAIL timeout errors=%0d checks=%0d", errs, checks);
      $fatal(1, "bench timeout");
   end
   initial begin
      test_reset();
      test_both_read();
      test_write_burst();
      test_starve();
      test_fifo_full();
      test_orphan_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
